mips16_run_ctrl: RTL and testbench
==================================

Name: mips16_run_ctrl

Overview:
Run-control sequencer for the 16-bit single-cycle MIPS core.
- Accepts byte-wide host commands from the Tiny Tapeout pins.
- Loads the instruction memory, starts and halts execution, single-steps, and resets the core.
- Stops execution on a one-entry PC breakpoint.
- Sits between the pin wrapper and the core, and owns the core's clock-enable, reset and imem write port.

Parameters:
IMEM_DEPTH, 16, instruction memory words.
ADDR_W, 4, word address width (log2 IMEM_DEPTH).
RST_CYCLES, 2, cycles cpu_rst is held on a RESET command.

Ports:
clk  in  1  clock, single domain.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  host command strobe.
cmd_ready  out  1  controller can accept a command this cycle.
cmd_op  in  3  0 NOP, 1 LOAD, 2 DATA, 3 RUN, 4 HALT, 5 STEP, 6 SETBP, 7 RESET.
cmd_data  in  8  payload (DATA byte; SETBP: bit7 enable, bits[ADDR_W-1:0] word index).
pc  in  16  core byte PC.
cpu_en  out  1  core advances one instruction on a clk edge where cpu_en=1.
cpu_rst  out  1  core reset.
imem_we  out  1  instruction memory write strobe.
imem_addr  out  ADDR_W  write word address.
imem_wdata  out  16  write data.
state_o  out  3  current state encoding.
bp_hit  out  1  sticky: breakpoint stopped execution.
err  out  1  sticky: DATA received outside a load, or illegal command in the current state.

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - state IDLE, cpu_en=0, cpu_rst=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - bp_hit=0, err=0, breakpoint disabled with index 0.
- A command is accepted on a clk edge where cmd_valid && cmd_ready.
- cmd_ready = 1 in IDLE, LOAD_LO, LOAD_HI and RUN; 0 in STEP and CPURST. It is combinational from state, so it is 1 right after reset.
- States and encodings: IDLE=0, LOAD_LO=1, LOAD_HI=2, RUN=3, STEP=4, CPURST=5.
- IDLE:
  - LOAD: word counter <= 0, err <= 0, go to LOAD_LO.
  - RUN: bp_hit <= 0, skip <= 1, go to RUN.
  - STEP: bp_hit <= 0, go to STEP.
  - RESET: counter <= RST_CYCLES-1, go to CPURST.
  - SETBP: latch enable and index, stay.
  - HALT, NOP: no effect.
  - DATA: err <= 1.
- LOAD_LO:
  - DATA: low byte <= cmd_data, go to LOAD_HI.
- LOAD_HI:
  - DATA: register imem_we=1 for exactly one cycle on the next cycle, with imem_wdata={cmd_data, low byte} and imem_addr=counter.
  - Then counter increments. If counter was IMEM_DEPTH-1, go to IDLE; otherwise go to LOAD_LO.
- In either LOAD state:
  - HALT aborts to IDLE. Partially written words stay written; a pending low byte is discarded.
  - Any other non-DATA, non-NOP command sets err and is otherwise dropped.
- RUN:
  - cpu_en = !(bp_en && pc[ADDR_W:1]==bp_idx && !skip), combinational.
  - skip clears after the first RUN cycle, so resuming from a breakpoint PC executes that instruction.
  - When a breakpoint matches: cpu_en=0 that cycle (the instruction is not executed), bp_hit <= 1, go to IDLE.
  - HALT: go to IDLE; cpu_en is still 1 during the accepting cycle.
  - SETBP is accepted and updates the breakpoint live.
  - Other commands set err.
  - A HALT accepted in the same cycle as a breakpoint match goes to IDLE with bp_hit=1.
- STEP: cpu_en=1 for exactly one cycle, breakpoint ignored, then IDLE.
- CPURST: cpu_rst=1 and cpu_en=0 for RST_CYCLES cycles, then IDLE. The breakpoint setting is preserved.
- cpu_en=0 in every state other than RUN and STEP.
- The pc input is only sampled in RUN.
- rst at any time, including mid-load or mid-CPURST, immediately returns everything to its reset values. Mid-CPURST this drops cpu_rst.

Test Plan:
- Reset, then LOAD followed by 32 DATA bytes 0x00..0x1F → 16 imem_we pulses; word k written with {2k+1, 2k} (e.g. addr 3 = 0x0706); state returns to IDLE after the last byte; err=0.
- SETBP 0x85, then RUN with a pc model that advances by 2 per cpu_en starting at 0 → cpu_en high for exactly 5 cycles; cpu_en=0 when pc=10; bp_hit=1; state IDLE.
- From the previous stop, RUN again → the first cycle has cpu_en=1 at pc=10 (skip); execution continues; HALT stops it with cpu_en low the cycle after acceptance.
- STEP from IDLE → one cpu_en pulse, cmd_ready=0 for that cycle, back in IDLE. RESET → cpu_rst high for 2 cycles, cmd_ready=0 for those cycles.
- DATA sent in IDLE → err=1. LOAD, 3 DATA bytes, then HALT → one word written at addr 0, state IDLE. The next LOAD clears err.
- Assert rst during LOAD_HI and during CPURST → all outputs return to their reset values on the next edge; no imem_we pulse occurs.

Source files
------------

// File: rtl/mips16_run_ctrl_if.sv
// Host command channel between the pin wrapper and the run-control sequencer.
//
// Handshake: a command (cmd_op, cmd_data) transfers on a clk edge where
// cmd_valid && cmd_ready. The host holds cmd_valid/cmd_op/cmd_data stable
// until that edge; cmd_ready depends only on the controller state, never
// on cmd_valid.
interface mips16_run_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/mips16_run_ctrl.sv
// Run-control sequencer for the 16-bit single-cycle MIPS core: loads imem
// from host bytes, runs/halts/steps/resets the core, and stops on a
// one-entry PC breakpoint.
module mips16_run_ctrl #(
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mips16_run_ctrl_if.slave  cmd,
    input  logic [15:0]       pc,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [2:0]        state_o,
    output logic              bp_hit,
    output logic              err
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [RC_W-1:0]   RST_INIT  = RC_W'(RST_CYCLES - 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_DATA  = 3'd2;
    localparam logic [2:0] OP_RUN   = 3'd3;
    localparam logic [2:0] OP_HALT  = 3'd4;
    localparam logic [2:0] OP_STEP  = 3'd5;
    localparam logic [2:0] OP_SETBP = 3'd6;
    localparam logic [2:0] OP_RESET = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_LO = 3'd1,
        LOAD_HI = 3'd2,
        RUN     = 3'd3,
        STEP    = 3'd4,
        CPURST  = 3'd5
    } state_t;

    state_t            state, state_n;
    logic              ready;
    logic              accept;
    logic              bp_match;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        low_byte;
    logic              skip;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_idx;
    logic [RC_W-1:0]   rst_cnt;

    // Only the word-index bits of the byte PC take part in the breakpoint.
    logic unused_pc;
    assign unused_pc = ^{pc[15:ADDR_W+1], pc[0]};

    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid && ready;
    assign state_o       = state;
    // skip masks the match on the first RUN cycle so a resume from the
    // breakpoint PC executes that instruction.
    assign bp_match      = bp_en && (pc[ADDR_W:1] == bp_idx) && !skip;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode plus combinational core controls and cmd_ready.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        cpu_en  = 1'b0;
        cpu_rst = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_LOAD:  state_n = LOAD_LO;
                        OP_RUN:   state_n = RUN;
                        OP_STEP:  state_n = STEP;
                        OP_RESET: state_n = CPURST;
                        default:  state_n = IDLE;
                    endcase
                end
            end
            LOAD_LO: begin
                ready = 1'b1;
                if (accept && cmd.cmd_op == OP_DATA)      state_n = LOAD_HI;
                else if (accept && cmd.cmd_op == OP_HALT) state_n = IDLE;
            end
            LOAD_HI: begin
                ready = 1'b1;
                if (accept && cmd.cmd_op == OP_DATA)
                    state_n = (cnt == LAST_WORD) ? IDLE : LOAD_LO;
                else if (accept && cmd.cmd_op == OP_HALT)
                    state_n = IDLE;
            end
            RUN: begin
                ready  = 1'b1;
                cpu_en = !bp_match;
                if (bp_match || (accept && cmd.cmd_op == OP_HALT)) state_n = IDLE;
            end
            STEP: begin
                cpu_en  = 1'b1;
                state_n = IDLE;
            end
            CPURST: begin
                cpu_rst = 1'b1;
                if (rst_cnt == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: load counter, imem write port, breakpoint and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            low_byte   <= '0;
            skip       <= 1'b0;
            bp_en      <= 1'b0;
            bp_idx     <= '0;
            rst_cnt    <= '0;
            bp_hit     <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                cnt <= '0;
                                err <= 1'b0;
                            end
                            OP_RUN: begin
                                bp_hit <= 1'b0;
                                skip   <= 1'b1;
                            end
                            OP_STEP:  bp_hit  <= 1'b0;
                            OP_RESET: rst_cnt <= RST_INIT;
                            OP_SETBP: begin
                                bp_en  <= cmd.cmd_data[7];
                                bp_idx <= cmd.cmd_data[ADDR_W-1:0];
                            end
                            OP_DATA:  err <= 1'b1;
                            default:  ;
                        endcase
                    end
                end
                LOAD_LO, LOAD_HI: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_DATA: begin
                                if (state == LOAD_LO) begin
                                    low_byte <= cmd.cmd_data;
                                end else begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= cnt;
                                    imem_wdata <= {cmd.cmd_data, low_byte};
                                    cnt        <= cnt + 1'b1;
                                end
                            end
                            OP_NOP, OP_HALT: ;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    skip <= 1'b0;
                    if (bp_match) bp_hit <= 1'b1;
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_NOP, OP_HALT: ;
                            OP_SETBP: begin
                                bp_en  <= cmd.cmd_data[7];
                                bp_idx <= cmd.cmd_data[ADDR_W-1:0];
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                CPURST: begin
                    if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips16_run_ctrl.sv
// Directed bench for mips16_run_ctrl: imem writes and executed PCs are
// pushed to expected queues and popped by a negedge monitor.
module tb_mips16_run_ctrl;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_DATA  = 3'd2;
    localparam logic [2:0] OP_RUN   = 3'd3;
    localparam logic [2:0] OP_HALT  = 3'd4;
    localparam logic [2:0] OP_STEP  = 3'd5;
    localparam logic [2:0] OP_SETBP = 3'd6;
    localparam logic [2:0] OP_RESET = 3'd7;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        cpu_en;
    logic        cpu_rst;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [2:0]  state_o;
    logic        bp_hit;
    logic        err;

    mips16_run_ctrl_if bus ();

    mips16_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .state_o    (state_o),
        .bp_hit     (bp_hit),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    logic [19:0] wr_q[$];
    logic [15:0] pc_q[$];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: PC advances by one instruction per enabled edge.
    always @(posedge clk) begin
        if (rst || cpu_rst) pc <= 16'd0;
        else if (cpu_en)    pc <= pc + 16'd2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every imem write and every enabled core cycle pops an expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_q.size() == 0) chk("imem_we_unexpected", 32'd1, 32'd0);
            else begin
                logic [19:0] e;
                e = wr_q.pop_front();
                chk("imem_write", {12'd0, imem_addr, imem_wdata}, {12'd0, e});
            end
        end
        if (cpu_en === 1'b1) begin
            en_count++;
            if (pc_q.size() == 0) chk("cpu_en_unexpected", {16'd0, pc}, 32'hffff);
            else begin
                logic [15:0] ep;
                ep = pc_q.pop_front();
                chk("cpu_en_pc", {16'd0, pc}, {16'd0, ep});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers (all start and end 1 time unit after a posedge).
    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = 8'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (state_o != 3'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {29'd0, state_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic status(input logic [2:0] st, input logic e, input logic bp);
        @(negedge clk);
        chk("state", {29'd0, state_o}, {29'd0, st});
        chk("err", {31'd0, err}, {31'd0, e});
        chk("bp_hit", {31'd0, bp_hit}, {31'd0, bp});
        chk("cpu_en_idle", {31'd0, cpu_en}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
        chk("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = 8'd0;
        tick(2);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full image load: word k = {2k+1, 2k}.
        send(OP_LOAD, 8'd0);
        for (int k = 0; k < 16; k++) begin
            wr_q.push_back({4'(k), 8'(2 * k + 1), 8'(2 * k)});
            send(OP_DATA, 8'(2 * k));
            send(OP_DATA, 8'(2 * k + 1));
        end
        status(3'd0, 1'b0, 1'b0);

        // Breakpoint at word 5 (pc 10): five instructions run.
        send(OP_SETBP, 8'h85);
        for (int i = 0; i < 5; i++) pc_q.push_back(16'(2 * i));
        send(OP_RUN, 8'd0);
        wait_idle();
        status(3'd0, 1'b0, 1'b1);
        chk("en_count_bp", en_count, 32'd5);

        // Resume from the breakpoint PC, then HALT.
        for (int i = 0; i < 4; i++) pc_q.push_back(16'(10 + 2 * i));
        send(OP_RUN, 8'd0);
        tick(3);
        send(OP_HALT, 8'd0);
        status(3'd0, 1'b0, 1'b0);
        chk("en_count_halt", en_count, 32'd9);

        // Single step.
        pc_q.push_back(16'd18);
        send(OP_STEP, 8'd0);
        @(negedge clk);
        chk("step_state", {29'd0, state_o}, 32'd4);
        chk("step_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        status(3'd0, 1'b0, 1'b0);

        // Core reset: cpu_rst for two cycles, then idle.
        send(OP_RESET, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cpurst_cpu_rst", {31'd0, cpu_rst}, (i < 2) ? 32'd1 : 32'd0);
            chk("cpurst_ready", {31'd0, bus.cmd_ready}, (i < 2) ? 32'd0 : 32'd1);
            chk("cpurst_state", {29'd0, state_o}, (i < 2) ? 32'd5 : 32'd0);
        end
        @(posedge clk);
        #1;

        // Breakpoint survives the core reset.
        for (int i = 0; i < 5; i++) pc_q.push_back(16'(2 * i));
        send(OP_RUN, 8'd0);
        wait_idle();
        status(3'd0, 1'b0, 1'b1);

        // DATA in IDLE is an error; the next LOAD clears it.
        send(OP_DATA, 8'h55);
        status(3'd0, 1'b1, 1'b1);
        send(OP_LOAD, 8'd0);
        status(3'd1, 1'b0, 1'b1);
        wr_q.push_back({4'd0, 16'hBBAA});
        send(OP_DATA, 8'hAA);
        send(OP_DATA, 8'hBB);
        send(OP_DATA, 8'hCC);
        send(OP_HALT, 8'd0);
        status(3'd0, 1'b0, 1'b1);

        // Illegal command mid-load.
        send(OP_LOAD, 8'd0);
        send(OP_RUN, 8'd0);
        status(3'd1, 1'b1, 1'b1);
        send(OP_HALT, 8'd0);

        // rst in LOAD_HI with a DATA byte presented: no write.
        send(OP_LOAD, 8'd0);
        send(OP_DATA, 8'h11);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DATA;
        bus.cmd_data  = 8'h22;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // rst in CPURST drops cpu_rst at once.
        send(OP_RESET, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Breakpoint is disabled after rst: runs through pc 10.
        for (int i = 0; i < 8; i++) pc_q.push_back(16'(2 * i));
        send(OP_RUN, 8'd0);
        tick(7);
        send(OP_HALT, 8'd0);
        status(3'd0, 1'b0, 1'b0);

        tick(3);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        chk("pc_q_empty", pc_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
